// File: rtl/countdown_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | countdown_pkg                                                        |
// | Shared state encoding and 7-segment lookup for the countdown engine. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package countdown_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b0000001;

    // Active-low, bit6=a .. bit0=g; anything outside 0-9 goes dark.
    function automatic logic [6:0] seg_of(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seg7_decoder                                                         |
// | Registered BCD to active-low segment decoder, resets to the "0" code.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seg7_decoder
    import countdown_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    logic [6:0] r_seg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_seg <= SEG_ZERO;
        end else begin
            r_seg <= seg_of(bcd);
        end
    end

    assign seg = r_seg;

endmodule
`default_nettype wire

// File: rtl/countdown_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | countdown_core                                                       |
// | Loads binary seconds, converts to M:SS by repeated subtraction and   |
// | counts down on a 1 Hz enable, driving three registered digit codes.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module countdown_core
    import countdown_pkg::*;
#(
    parameter int SUB_MIN  = 60,
    parameter int SUB_TENS = 10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       load,
    input  logic       start_stop,
    input  logic [7:0] switch_number,
    output logic [6:0] seconds_ones,
    output logic [6:0] seconds_tens,
    output logic [6:0] minutes,
    output logic       running,
    output logic       done
);

    localparam logic [7:0] c_sub_min  = 8'(SUB_MIN);
    localparam logic [7:0] c_sub_tens = 8'(SUB_TENS);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_work;
    logic [7:0] w_work_nxt;
    logic [3:0] r_min;
    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic [3:0] w_min_nxt;
    logic [3:0] w_tens_nxt;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_dec_min;
    logic [3:0] w_dec_tens;
    logic [3:0] w_dec_ones;
    logic       w_is_zero;
    logic       w_dec_zero;

    assign w_is_zero = (r_min == 4'd0) && (r_tens == 4'd0) && (r_ones == 4'd0);

    // One-second decrement with borrow; holds at 0:00 rather than wrapping.
    always_comb begin
        w_dec_min  = r_min;
        w_dec_tens = r_tens;
        w_dec_ones = r_ones;
        if (r_ones != 4'd0) begin
            w_dec_ones = r_ones - 4'd1;
        end else if (r_tens != 4'd0) begin
            w_dec_tens = r_tens - 4'd1;
            w_dec_ones = 4'd9;
        end else if (r_min != 4'd0) begin
            w_dec_min  = r_min - 4'd1;
            w_dec_tens = 4'd5;
            w_dec_ones = 4'd9;
        end
    end

    assign w_dec_zero = (w_dec_min == 4'd0) && (w_dec_tens == 4'd0) && (w_dec_ones == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_min_nxt   = r_min;
        w_tens_nxt  = r_tens;
        w_ones_nxt  = r_ones;
        if (load) begin
            w_work_nxt  = switch_number;
            w_min_nxt   = 4'd0;
            w_tens_nxt  = 4'd0;
            w_ones_nxt  = 4'd0;
            w_state_nxt = ST_CONV;
        end else begin
            case (r_state)
                ST_CONV: begin
                    if (r_work >= c_sub_min) begin
                        w_work_nxt = r_work - c_sub_min;
                        w_min_nxt  = r_min + 4'd1;
                    end else if (r_work >= c_sub_tens) begin
                        w_work_nxt = r_work - c_sub_tens;
                        w_tens_nxt = r_tens + 4'd1;
                    end else begin
                        w_ones_nxt  = r_work[3:0];
                        w_state_nxt = ST_PAUSE;
                    end
                end
                // IDLE always holds 0:00, so it shares the PAUSE behaviour.
                ST_IDLE, ST_PAUSE: begin
                    if (start_stop) begin
                        w_state_nxt = w_is_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_stop) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick) begin
                        w_min_nxt  = w_dec_min;
                        w_tens_nxt = w_dec_tens;
                        w_ones_nxt = w_dec_ones;
                        if (w_dec_zero) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_DONE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_work  <= 8'd0;
            r_min   <= 4'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_min   <= w_min_nxt;
            r_tens  <= w_tens_nxt;
            r_ones  <= w_ones_nxt;
        end
    end

    assign running = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);

    seg7_decoder u_seg_min (
        .clock (clock),
        .reset (reset),
        .bcd   (r_min),
        .seg   (minutes)
    );

    seg7_decoder u_seg_tens (
        .clock (clock),
        .reset (reset),
        .bcd   (r_tens),
        .seg   (seconds_tens)
    );

    seg7_decoder u_seg_ones (
        .clock (clock),
        .reset (reset),
        .bcd   (r_ones),
        .seg   (seconds_ones)
    );

endmodule
`default_nettype wire
